apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator: converts a valid/ready request channel plus a valid/ready response channel into APB3 transfers (PSEL/PENABLE/PREADY/PSLVERR).
- Sits between a CPU-side load/store unit or debug port and the APB peripheral bus that hosts the gpio and other slave blocks.
- Adds a bounded-wait watchdog so a hung slave cannot stall the initiator.

---
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 tb/tb_apb_master_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready request in, valid/ready response out,
// with a watchdog that aborts an ACCESS phase whose slave never asserts PREADY.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          wdog_d   = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY wins over the watchdog threshold on the same edge.
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0 && wdog_q == WD_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is either a register or a decode of the state register.
  assign req_ready   = (state_q == IDLE);
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs driven and outputs sampled on the falling edge.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int checks = 0;
  int failures = 0;

  apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Checks PSEL/PENABLE/rsp_valid/req_ready together.
  task automatic check_ctl(input string tag, input logic psel, input logic pen,
                           input logic rv, input logic rr);
    check({tag, ".psel"}, 32'(PSEL), 32'(psel));
    check({tag, ".penable"}, 32'(PENABLE), 32'(pen));
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    step(); step();
    check_ctl("reset", 0, 0, 0, 1);
    check("reset.paddr", PADDR, 32'h0);
    check("reset.rsp_rdata", rsp_rdata, 32'h0);
    check("reset.rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    step();
    $display("txn reset done");

    // Write to a zero-wait slave.
    issue(1'b1, 32'h8, 32'hA5A5_0001);
    check_ctl("wr.setup", 1, 0, 0, 0);
    check("wr.paddr", PADDR, 32'h8);
    check("wr.pwdata", PWDATA, 32'hA5A5_0001);
    check("wr.pwrite", 32'(PWRITE), 32'h1);
    step();
    check_ctl("wr.access", 1, 1, 0, 0);
    step();
    check_ctl("wr.resp", 0, 0, 1, 0);
    check("wr.rsp_rdata", rsp_rdata, 32'h0);
    check("wr.rsp_err", 32'(rsp_err), 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_ctl("wr.idle", 0, 0, 0, 1);
    $display("txn write addr=0x8 done");

    // Read with one slave wait state.
    PREADY = 1'b0; PRDATA = 32'h0000_00F0;
    issue(1'b0, 32'h10, 32'h0);
    check_ctl("rd1w.setup", 1, 0, 0, 0);
    step();
    check_ctl("rd1w.access1", 1, 1, 0, 0);
    check("rd1w.paddr1", PADDR, 32'h10);
    step();
    check_ctl("rd1w.access2", 1, 1, 0, 0);
    check("rd1w.paddr2", PADDR, 32'h10);
    PREADY = 1'b1;
    step();
    check_ctl("rd1w.resp", 0, 0, 1, 0);
    check("rd1w.rsp_rdata", rsp_rdata, 32'hF0);
    check("rd1w.rsp_err", 32'(rsp_err), 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("txn read-1wait addr=0x10 done");

    // Slave error on a read.
    PSLVERR = 1'b1; PRDATA = 32'h0000_1234;
    issue(1'b0, 32'h20, 32'h0);
    step(); step();
    PSLVERR = 1'b0;
    check_ctl("slverr.resp", 0, 0, 1, 0);
    check("slverr.rsp_err", 32'(rsp_err), 32'h1);
    check("slverr.rsp_timeout", 32'(rsp_timeout), 32'h0);
    check("slverr.rsp_rdata", rsp_rdata, 32'h1234);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("txn slverr addr=0x20 done");

    // Watchdog abort after exactly four ACCESS cycles.
    PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    issue(1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_ctl($sformatf("tmo.access%0d", i + 1), 1, 1, 0, 0);
    end
    step();
    check_ctl("tmo.resp", 0, 0, 1, 0);
    check("tmo.rsp_err", 32'(rsp_err), 32'h1);
    check("tmo.rsp_timeout", 32'(rsp_timeout), 32'h1);
    check("tmo.rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("txn timeout addr=0x30 done");

    // PREADY on the 4th ACCESS cycle beats the watchdog.
    PRDATA = 32'h0000_0055;
    issue(1'b0, 32'h34, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_ctl($sformatf("tmoedge.access%0d", i + 1), 1, 1, 0, 0);
    end
    PREADY = 1'b1;
    step();
    check_ctl("tmoedge.resp", 0, 0, 1, 0);
    check("tmoedge.rsp_err", 32'(rsp_err), 32'h0);
    check("tmoedge.rsp_timeout", 32'(rsp_timeout), 32'h0);
    check("tmoedge.rsp_rdata", rsp_rdata, 32'h55);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("txn timeout-edge addr=0x34 done");

    // Back-to-back requests with response backpressure.
    PRDATA = 32'h0000_0077;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    step();
    check_ctl("bp.setup1", 1, 0, 0, 0);
    req_addr = 32'h44;
    step(); step();
    PRDATA = 32'h0000_0099;
    for (int i = 0; i < 5; i++) begin
      check_ctl($sformatf("bp.hold%0d", i), 0, 0, 1, 0);
      check($sformatf("bp.hold%0d.rdata", i), rsp_rdata, 32'h77);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check_ctl("bp.idle", 0, 0, 0, 1);
    step();
    req_valid = 1'b0;
    check_ctl("bp.setup2", 1, 0, 0, 0);
    check("bp.paddr2", PADDR, 32'h44);
    step(); step();
    check_ctl("bp.resp2", 0, 0, 1, 0);
    check("bp.rsp_rdata2", rsp_rdata, 32'h99);
    step();
    rsp_ready = 1'b0;
    check_ctl("bp.idle2", 0, 0, 0, 1);
    $display("txn backpressure addr=0x40,0x44 done");

    // Reset during a waited read discards the transfer.
    PREADY = 1'b0;
    issue(1'b0, 32'h50, 32'h0);
    step();
    check_ctl("rstmid.access", 1, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0; PREADY = 1'b1; rsp_ready = 1'b1;
    check_ctl("rstmid.after", 0, 0, 0, 1);
    check("rstmid.paddr", PADDR, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rstmid.norsp%0d", i), 32'(rsp_valid), 32'h0);
    end
    $display("txn reset-mid-access addr=0x50 done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
